// File: rtl/reaction_ctrl.sv
// reaction_ctrl: game sequencer for the reaction-timer display.
// It runs the Idle/Ready/Go/Hit/Miss state machine and draws a pseudo-random
// arm delay from a free-running LFSR. It times the response as a 6-digit BCD
// count of microseconds, keeps the last and best times, and drives the
// status, colour and BCD inputs of the layout/text renderer.
module reaction_ctrl #(
  parameter int US_DIV          = 25,   // clk cycles per 1 us tick
  parameter int US_PER_MS       = 1000, // us ticks per ms tick
  parameter int DELAY_MIN_MS    = 1000, // minimum arm delay in ms
  parameter int DELAY_SPAN_BITS = 10    // random part of the arm delay, in LFSR bits
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn,
  input  logic        i_bcdmux,
  output logic [2:0]  o_dst,
  output logic [23:0] o_bcd,
  output logic        o_lit,
  output logic        o_miss,
  output logic        o_init
);

  // State encoding matches the status code shown to the renderer.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_READY = 3'b001,
    S_GO    = 3'b010,
    S_MISS  = 3'b011,
    S_HIT   = 3'b110
  } state_t;

  localparam int US_W  = (US_DIV > 1)    ? $clog2(US_DIV)    : 1;
  localparam int MS_W  = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
  localparam int DLY_W = $clog2(DELAY_MIN_MS + 2**DELAY_SPAN_BITS + 1);

  localparam logic [US_W-1:0]  US_LAST  = US_W'(US_DIV - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(US_PER_MS - 1);
  localparam logic [DLY_W-1:0] DLY_MIN  = DLY_W'(DELAY_MIN_MS);
  localparam logic [23:0]      CNT_MAX  = 24'h999999;
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  localparam logic [15:0]      LFSR_MASK = 16'hB400;

  // Increment a 6-digit BCD value; the carry ripples through all digits
  // in the same cycle, so 000999 becomes 001000 in one step.
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 6; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] >= 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t state;
  state_t next_state;

  logic             btn_q;      // i_btn sampled once
  logic             press_q;    // one-cycle pulse, the cycle after i_btn rises
  logic [15:0]      lfsr;
  logic [US_W-1:0]  us_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic [DLY_W-1:0] delay_ms;   // remaining arm delay while in READY
  logic [23:0]      cnt;        // BCD response timer while in GO
  logic [23:0]      last;
  logic [23:0]      best;

  logic       us_tick;
  logic       ms_tick;
  logic       enter_ready;
  logic       enter_go;
  logic [2:0] dst_d;
  logic       lit_d;
  logic       miss_d;

  assign us_tick     = (us_cnt == US_LAST);
  assign ms_tick     = us_tick && (ms_cnt == MS_LAST);
  assign enter_ready = (next_state == S_READY) && (state != S_READY);
  assign enter_go    = (next_state == S_GO)    && (state != S_GO);

  // Button edge detector: only a 0->1 transition of i_btn counts as a press.
  always_ff @(posedge i_clk) begin
    // NOTE: every clocked register uses non-blocking assignments so that all
    // flops update together from the values held before the edge.
    if (i_rst) begin
      // NOTE: btn_q resets to 1 so a button held down through reset is not
      // seen as a press; a real press needs i_btn to fall and rise again.
      btn_q   <= 1'b1;
      press_q <= 1'b0;
    end else begin
      btn_q   <= i_btn;
      press_q <= i_btn & ~btn_q;
    end
  end

  // 16-bit Galois LFSR, stepping every cycle; a non-zero seed never reaches zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

  // State register plus registered status outputs decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      o_dst  <= 3'b000;
      o_lit  <= 1'b0;
      o_miss <= 1'b0;
    end else begin
      state  <= next_state;
      o_dst  <= dst_d;
      o_lit  <= lit_d;
      o_miss <= miss_d;
    end
  end

  // Next-state logic; a press always wins over a simultaneous delay expiry
  // (early press) and over a simultaneous timer overflow (counts as a hit).
  always_comb begin
    // NOTE: default first, so no path through this block leaves next_state
    // unassigned and no latch is inferred.
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (press_q) next_state = S_READY;
      end
      S_READY: begin
        if (press_q)                next_state = S_MISS;
        else if (delay_ms == '0)    next_state = S_GO;
      end
      S_GO: begin
        if (press_q)                next_state = S_HIT;
        else if (cnt == CNT_MAX)    next_state = S_MISS;
      end
      S_HIT, S_MISS: begin
        if (press_q) next_state = S_READY;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode: status code equals the state encoding.
  always_comb begin
    dst_d  = next_state;
    lit_d  = (next_state == S_GO);
    miss_d = (next_state == S_MISS);
  end

  // us/ms prescalers: run only while a delay or a response is being timed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      us_cnt <= '0;
      ms_cnt <= '0;
    end else if (enter_ready) begin
      us_cnt <= '0;
      ms_cnt <= '0;
    end else if (enter_go) begin
      us_cnt <= '0;
    end else if (state == S_READY || state == S_GO) begin
      us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
      if (us_tick) begin
        ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
      end
    end
  end

  // Arm delay: loaded from the LFSR on the READY entry edge, counts down in ms.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      delay_ms <= '0;
    end else if (enter_ready) begin
      delay_ms <= DLY_MIN + DLY_W'(lfsr[DELAY_SPAN_BITS-1:0]);
    end else if (state == S_READY && ms_tick && delay_ms != '0) begin
      delay_ms <= delay_ms - 1'b1;
    end
  end

  // Response timer: cleared on GO entry, one BCD increment per us tick,
  // saturating at 999999 where the state machine declares a timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (enter_go) begin
      cnt <= '0;
    end else if (state == S_GO && next_state == S_GO && us_tick && cnt != CNT_MAX) begin
      cnt <= bcd_inc(cnt);
    end
  end

  // Results: last captures the timer on the press-detect cycle; best follows
  // one cycle later, once last holds the new value. BCD digit order makes a
  // plain unsigned compare valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last   <= '0;
      best   <= '0;
      o_init <= 1'b1;
    end else begin
      if (state == S_GO && press_q) begin
        last <= cnt;
      end
      if (state == S_HIT && (o_init || last < best)) begin
        best   <= last;
        o_init <= 1'b0;
      end
    end
  end

  // Zero-latency selection: the renderer switches i_bcdmux per text row.
  assign o_bcd = i_bcdmux ? best : last;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with shortened timing parameters:
// 2 clk per us, 4 us per ms, arm delay 3..6 ms.
module tb_reaction_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic        bcdmux;
  logic [2:0]  dst;
  logic [23:0] bcd;
  logic        lit;
  logic        miss;
  logic        init;

  int total = 0;
  int bad   = 0;

  reaction_ctrl #(
    .US_DIV          (2),
    .US_PER_MS       (4),
    .DELAY_MIN_MS    (3),
    .DELAY_SPAN_BITS (2)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn    (btn),
    .i_bcdmux (bcdmux),
    .o_dst    (dst),
    .o_bcd    (bcd),
    .o_lit    (lit),
    .o_miss   (miss),
    .o_init   (init)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [2:0] e_dst,
                              input logic e_lit, input logic e_miss);
    check({tag, "_dst"},  {21'b0, dst},  {21'b0, e_dst});
    check({tag, "_lit"},  {23'b0, lit},  {23'b0, e_lit});
    check({tag, "_miss"}, {23'b0, miss}, {23'b0, e_miss});
  endtask

  task automatic check_bcd(input string tag, input logic [23:0] e_last, input logic [23:0] e_best);
    bcdmux = 1'b0;
    #1;
    check({tag, "_last"}, bcd, e_last);
    bcdmux = 1'b1;
    #1;
    check({tag, "_best"}, bcd, e_best);
    bcdmux = 1'b0;
  endtask

  // One-cycle button pulse; returns on the negedge after the FSM has reacted.
  task automatic press();
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns on the first negedge where o_lit is high (or after the bound).
  task automatic wait_go(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (lit) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_go_reached"}, {23'b0, seen}, 24'h000001);
  endtask

  // Start a round and press so the timer reads k_us on the press-detect cycle.
  // The timer becomes j on the 2j-th edge after GO entry; the button rises
  // at the negedge 2k-1 cycles after o_lit is seen, is sampled on edge 2k,
  // and the FSM captures the timer on edge 2k+1.
  task automatic do_hit(input string tag, input int k_us);
    press();
    wait_go(tag);
    repeat (2 * k_us - 1) @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    check_status(tag, 3'b110, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    btn    = 1'b0;
    bcdmux = 1'b0;

    // 1: reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_status("t1", 3'b000, 1'b0, 1'b0);
    check("t1_init", {23'b0, init}, 24'h000001);
    check_bcd("t1", 24'h000000, 24'h000000);

    // 2: first hit at 25 us sets both last and best
    do_hit("t2", 25);
    check_bcd("t2", 24'h000025, 24'h000025);
    check("t2_init", {23'b0, init}, 24'h000000);

    // 3: early press in READY ends the round as a miss, results untouched
    press();
    check("t3_ready", {21'b0, dst}, 24'h000001);
    press();
    check_status("t3", 3'b011, 1'b0, 1'b1);
    check_bcd("t3", 24'h000025, 24'h000025);

    // 4: best tracks the minimum over 40, 30, 50 us
    do_reset();
    do_hit("t4a", 40);
    check_bcd("t4a", 24'h000040, 24'h000040);
    do_hit("t4b", 30);
    check_bcd("t4b", 24'h000030, 24'h000030);
    do_hit("t4c", 50);
    check_bcd("t4c", 24'h000050, 24'h000030);
    check("t4_init", {23'b0, init}, 24'h000000);

    // 5: BCD carry ripple, then timeout at 999999 without a press
    press();
    wait_go("t5");
    force dut.cnt = 24'h000999;
    #1;
    release dut.cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dut.cnt !== 24'h000999) break;
    end
    check("t5_carry", dut.cnt, 24'h001000);
    check("t5_still_go", {23'b0, lit}, 24'h000001);
    force dut.cnt = 24'h999990;
    #1;
    release dut.cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (miss) break;
    end
    check_status("t5_timeout", 3'b011, 1'b0, 1'b1);
    check("t5_cnt_max", dut.cnt, 24'h999999);
    check_bcd("t5", 24'h000050, 24'h000030);

    // 6: reset in the middle of GO with the button held through reset
    press();
    wait_go("t6");
    btn = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_status("t6_rst", 3'b000, 1'b0, 1'b0);
    check("t6_init", {23'b0, init}, 24'h000001);
    check_bcd("t6", 24'h000000, 24'h000000);
    repeat (4) @(negedge clk);
    check("t6_held", {21'b0, dst}, 24'h000000);
    btn = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    check("t6_repress", {21'b0, dst}, 24'h000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
